// File: rtl/multi_lift_pkg.sv
// rtl/multi_lift_pkg.sv - shared state codes, width helpers and distance function for the hall dispatcher
package multi_lift_pkg;

  typedef logic [1:0] disp_state_t;

  localparam disp_state_t IDLE   = 2'd0;
  localparam disp_state_t PICK   = 2'd1;
  localparam disp_state_t SCAN   = 2'd2;
  localparam disp_state_t ASSIGN = 2'd3;

  function automatic int flw_of(input int n_floors);
    return (n_floors <= 2) ? 1 : $clog2(n_floors);
  endfunction

  function automatic int lw_of(input int n_lifts);
    return (n_lifts <= 2) ? 1 : $clog2(n_lifts);
  endfunction

  // Two extra bits hold distance plus two direction penalties of up to N_FLOORS each.
  function automatic int cost_w_of(input int n_floors);
    return flw_of(n_floors) + 2;
  endfunction

  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/lift_cost_calc.sv
// rtl/lift_cost_calc.sv - combinational dispatch cost of one lift for one hall call
module lift_cost_calc
  import multi_lift_pkg::*;
#(
  parameter int N_FLOORS = 12,
  parameter int DIR_PEN  = N_FLOORS,
  localparam int FLW     = flw_of(N_FLOORS),
  localparam int COST_W  = cost_w_of(N_FLOORS)
) (
  input  logic [FLW-1:0]    lift_floor,
  input  logic              lift_motion,
  input  logic              lift_direction,
  input  logic              lift_in_service,
  input  logic [FLW-1:0]    call_floor,
  input  logic              call_dir,
  output logic [COST_W-1:0] cost,
  output logic              eligible
);

  localparam logic [COST_W-1:0] PEN = COST_W'(DIR_PEN);

  logic moving_away;
  logic opposite_dir;

  always_comb begin
    moving_away  = lift_motion &
                   ((lift_direction & (lift_floor > call_floor)) |
                    (~lift_direction & (lift_floor < call_floor)));
    opposite_dir = lift_motion & (lift_direction != call_dir);
    cost         = COST_W'(abs_diff(int'(lift_floor), int'(call_floor)))
                 + (moving_away ? PEN : '0)
                 + (opposite_dir ? PEN : '0);
    eligible     = lift_in_service;
  end

endmodule

// File: rtl/multi_lift_hall_dispatcher.sv
// rtl/multi_lift_hall_dispatcher.sv - hall call latch, serial lowest-cost lift dispatch and per-lift request merge
module multi_lift_hall_dispatcher
  import multi_lift_pkg::*;
#(
  parameter int N_FLOORS = 12,
  parameter int N_LIFTS  = 4,
  parameter int DIR_PEN  = N_FLOORS,
  localparam int FLW     = flw_of(N_FLOORS),
  localparam int LW      = lw_of(N_LIFTS),
  localparam int COST_W  = cost_w_of(N_FLOORS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_FLOORS-1:0]         hall_up,
  input  logic [N_FLOORS-1:0]         hall_dn,
  input  logic [N_LIFTS*N_FLOORS-1:0] car_rqst,
  input  logic [N_LIFTS*FLW-1:0]      lift_floor,
  input  logic [N_LIFTS-1:0]          lift_motion,
  input  logic [N_LIFTS-1:0]          lift_direction,
  input  logic [N_LIFTS-1:0]          lift_door_open,
  input  logic [N_LIFTS-1:0]          lift_in_service,
  output logic [N_LIFTS*N_FLOORS-1:0] flr_rqst,
  output logic [N_FLOORS-1:0]         up_pending,
  output logic [N_FLOORS-1:0]         dn_pending,
  output logic                        assign_valid,
  output logic [LW-1:0]               assign_lift,
  output logic [FLW-1:0]              assign_floor,
  output logic                        assign_dir
);

  logic [N_FLOORS-1:0] up_pend, dn_pend;
  logic [N_FLOORS-1:0] up_own_v, dn_own_v;
  logic [LW-1:0]       up_owner [N_FLOORS];
  logic [LW-1:0]       dn_owner [N_FLOORS];
  logic [FLW-1:0]      lf [N_LIFTS];

  logic [N_FLOORS-1:0] up_free, dn_free;
  logic [N_FLOORS-1:0] up_clr, dn_clr, up_drop, dn_drop;

  disp_state_t         state;
  logic [FLW-1:0]      call_floor;
  logic                call_dir;
  logic [LW-1:0]       scan_idx;
  logic [COST_W-1:0]   best_cost;
  logic [LW-1:0]       best_idx;
  logic                best_valid;

  logic                pick_found;
  logic [FLW-1:0]      pick_floor;
  logic                pick_dir;
  logic [COST_W-1:0]   cost;
  logic                eligible;
  logic                take;
  logic                last_lift;
  logic                do_assign;
  logic [N_LIFTS*N_FLOORS-1:0] flr_next;

  always_comb begin
    for (int i = 0; i < N_LIFTS; i++) begin
      lf[i] = lift_floor[i*FLW +: FLW];
    end
  end

  assign up_free = up_pend & ~up_own_v;
  assign dn_free = dn_pend & ~dn_own_v;

  // An owned call is served when its owner stands at the floor with the door open.
  always_comb begin
    up_clr  = '0;
    dn_clr  = '0;
    up_drop = '0;
    dn_drop = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      up_clr[f]  = up_pend[f] & up_own_v[f] & (lf[up_owner[f]] == FLW'(f)) & lift_door_open[up_owner[f]];
      dn_clr[f]  = dn_pend[f] & dn_own_v[f] & (lf[dn_owner[f]] == FLW'(f)) & lift_door_open[dn_owner[f]];
      up_drop[f] = up_own_v[f] & ~lift_in_service[up_owner[f]];
      dn_drop[f] = dn_own_v[f] & ~lift_in_service[dn_owner[f]];
    end
  end

  // Descending scans so the lowest floor wins; up calls take precedence over down calls.
  always_comb begin
    pick_found = 1'b0;
    pick_floor = '0;
    pick_dir   = 1'b0;
    for (int f = N_FLOORS - 1; f >= 0; f--) begin
      if (dn_free[f]) begin
        pick_found = 1'b1;
        pick_floor = FLW'(f);
        pick_dir   = 1'b0;
      end
    end
    for (int f = N_FLOORS - 1; f >= 0; f--) begin
      if (up_free[f]) begin
        pick_found = 1'b1;
        pick_floor = FLW'(f);
        pick_dir   = 1'b1;
      end
    end
  end

  lift_cost_calc #(
    .N_FLOORS (N_FLOORS),
    .DIR_PEN  (DIR_PEN)
  ) u_cost (
    .lift_floor      (lf[scan_idx]),
    .lift_motion     (lift_motion[scan_idx]),
    .lift_direction  (lift_direction[scan_idx]),
    .lift_in_service (lift_in_service[scan_idx]),
    .call_floor      (call_floor),
    .call_dir        (call_dir),
    .cost            (cost),
    .eligible        (eligible)
  );

  assign take      = eligible & (~best_valid | (cost < best_cost));
  assign last_lift = (scan_idx == LW'(N_LIFTS - 1));
  assign do_assign = (state == ASSIGN) & (call_dir ? up_free[call_floor] : dn_free[call_floor]);

  assign assign_valid = do_assign;
  assign assign_lift  = do_assign ? best_idx : '0;
  assign assign_floor = do_assign ? call_floor : '0;
  assign assign_dir   = do_assign & call_dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      call_floor <= '0;
      call_dir   <= 1'b0;
      scan_idx   <= '0;
      best_cost  <= '0;
      best_idx   <= '0;
      best_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((|up_free) | (|dn_free)) state <= PICK;
        end
        PICK: begin
          if (pick_found) begin
            call_floor <= pick_floor;
            call_dir   <= pick_dir;
            scan_idx   <= '0;
            best_cost  <= '0;
            best_idx   <= '0;
            best_valid <= 1'b0;
            state      <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          if (take) begin
            best_valid <= 1'b1;
            best_cost  <= cost;
            best_idx   <= scan_idx;
          end
          if (last_lift) begin
            state <= (best_valid | take) ? ASSIGN : IDLE;
          end else begin
            scan_idx <= scan_idx + LW'(1);
          end
        end
        ASSIGN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Clear beats a same-cycle button press; a held button re-latches on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_pend  <= '0;
      dn_pend  <= '0;
      up_own_v <= '0;
      dn_own_v <= '0;
      for (int f = 0; f < N_FLOORS; f++) begin
        up_owner[f] <= '0;
        dn_owner[f] <= '0;
      end
    end else begin
      for (int f = 0; f < N_FLOORS; f++) begin
        if (up_clr[f]) begin
          up_pend[f]  <= 1'b0;
          up_own_v[f] <= 1'b0;
        end else begin
          if (hall_up[f]) up_pend[f] <= 1'b1;
          if (up_drop[f]) begin
            up_own_v[f] <= 1'b0;
          end else if (do_assign && call_dir && (call_floor == FLW'(f))) begin
            up_own_v[f] <= 1'b1;
            up_owner[f] <= best_idx;
          end
        end
        if (dn_clr[f]) begin
          dn_pend[f]  <= 1'b0;
          dn_own_v[f] <= 1'b0;
        end else begin
          if (hall_dn[f]) dn_pend[f] <= 1'b1;
          if (dn_drop[f]) begin
            dn_own_v[f] <= 1'b0;
          end else if (do_assign && !call_dir && (call_floor == FLW'(f))) begin
            dn_own_v[f] <= 1'b1;
            dn_owner[f] <= best_idx;
          end
        end
      end
    end
  end

  always_comb begin
    flr_next = '0;
    for (int i = 0; i < N_LIFTS; i++) begin
      for (int f = 0; f < N_FLOORS; f++) begin
        flr_next[i*N_FLOORS + f] = car_rqst[i*N_FLOORS + f]
                                 | (up_own_v[f] & (up_owner[f] == LW'(i)))
                                 | (dn_own_v[f] & (dn_owner[f] == LW'(i)));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flr_rqst <= '0;
    else        flr_rqst <= flr_next;
  end

  assign up_pending = up_pend;
  assign dn_pending = dn_pend;

endmodule

// File: tb/tb_multi_lift_hall_dispatcher.sv
// tb/tb_multi_lift_hall_dispatcher.sv - directed and randomized self-checking bench for the hall dispatcher
module tb_multi_lift_hall_dispatcher;

  localparam int NF  = 12;
  localparam int NL  = 4;
  localparam int FLW = 4;
  localparam int LW  = 2;
  localparam int PEN = 12;

  logic              clk;
  logic              reset;
  logic [NF-1:0]     hall_up, hall_dn;
  logic [NL*NF-1:0]  car_rqst;
  logic [NL*FLW-1:0] lift_floor;
  logic [NL-1:0]     lift_motion, lift_direction, lift_door_open, lift_in_service;
  logic [NL*NF-1:0]  flr_rqst;
  logic [NF-1:0]     up_pending, dn_pending;
  logic              assign_valid;
  logic [LW-1:0]     assign_lift;
  logic [FLW-1:0]    assign_floor;
  logic              assign_dir;

  int errors = 0;
  int checks = 0;

  int lfl [NL];
  bit mv [NL], dr [NL], door [NL], svc [NL];

  multi_lift_hall_dispatcher #(.N_FLOORS(NF), .N_LIFTS(NL), .DIR_PEN(PEN)) dut (
    .clk             (clk),
    .reset           (reset),
    .hall_up         (hall_up),
    .hall_dn         (hall_dn),
    .car_rqst        (car_rqst),
    .lift_floor      (lift_floor),
    .lift_motion     (lift_motion),
    .lift_direction  (lift_direction),
    .lift_door_open  (lift_door_open),
    .lift_in_service (lift_in_service),
    .flr_rqst        (flr_rqst),
    .up_pending      (up_pending),
    .dn_pending      (dn_pending),
    .assign_valid    (assign_valid),
    .assign_lift     (assign_lift),
    .assign_floor    (assign_floor),
    .assign_dir      (assign_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_cost(input int lfv, input bit mov, input bit dir, input int f, input bit cdir);
    int c;
    c = (lfv > f) ? lfv - f : f - lfv;
    if (mov && ((dir && lfv > f) || (!dir && lfv < f))) c += PEN;
    if (mov && (dir != cdir)) c += PEN;
    return c;
  endfunction

  function automatic int model_pick(input int f, input bit cdir);
    int best = -1;
    int bc = 0;
    for (int i = 0; i < NL; i++) begin
      if (svc[i]) begin
        int c = model_cost(lfl[i], mv[i], dr[i], f, cdir);
        if (best < 0 || c < bc) begin
          best = i;
          bc = c;
        end
      end
    end
    return best;
  endfunction

  task automatic drive_lifts();
    for (int i = 0; i < NL; i++) begin
      lift_floor[i*FLW +: FLW] = FLW'(lfl[i]);
      lift_motion[i]     = mv[i];
      lift_direction[i]  = dr[i];
      lift_door_open[i]  = door[i];
      lift_in_service[i] = svc[i];
    end
  endtask

  task automatic set_idle_lifts(input int f0, input int f1, input int f2, input int f3);
    lfl[0] = f0; lfl[1] = f1; lfl[2] = f2; lfl[3] = f3;
    for (int i = 0; i < NL; i++) begin
      mv[i] = 0; dr[i] = 0; door[i] = 0; svc[i] = 1;
    end
    drive_lifts();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    hall_up = '0;
    hall_dn = '0;
    car_rqst = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pulse_call(input int f, input bit up);
    if (up) hall_up[f] = 1'b1;
    else    hall_dn[f] = 1'b1;
    @(posedge clk);
    #1;
    hall_up = '0;
    hall_dn = '0;
  endtask

  task automatic wait_assign(input int budget, output bit got, output int n);
    got = 0;
    n = 0;
    while (!got && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (assign_valid) got = 1;
    end
  endtask

  initial begin
    bit got;
    int n;
    int f;
    bit up;
    int exp_l;
    logic [NL*NF-1:0] ev;

    reset = 1'b0;
    hall_up = '0;
    hall_dn = '0;
    car_rqst = '0;
    set_idle_lifts(0, 5, 9, 11);
    #1;
    chk("reset_flr", flr_rqst, 0);
    chk("reset_assign_valid", assign_valid, 0);
    do_reset();
    chk("reset_up_pending", up_pending, 0);
    chk("reset_dn_pending", dn_pending, 0);

    // reset asserted while the scan is running
    car_rqst = 48'h0000_0000_0F0F;
    pulse_call(6, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_flr", flr_rqst, {24'd0, 24'h000F0F});
    #2 reset = 1'b0;
    #1;
    chk("midscan_flr", flr_rqst, 0);
    chk("midscan_up_pending", up_pending, 0);
    chk("midscan_assign_valid", assign_valid, 0);
    chk("midscan_assign_lift", assign_lift, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    car_rqst = '0;
    wait_assign(10, got, n);
    chk("after_reset_no_assign", got, 0);
    chk("after_reset_pending", {up_pending, dn_pending}, 0);

    // nearest idle lift, latency from latch edge
    do_reset();
    set_idle_lifts(0, 5, 9, 11);
    pulse_call(6, 1);
    chk("t2_latched", up_pending[6], 1);
    wait_assign(12, got, n);
    chk("t2_got", got, 1);
    chk("t2_latency", n, 6);
    chk("t2_lift", assign_lift, 1);
    chk("t2_floor", assign_floor, 6);
    chk("t2_dir", assign_dir, 1);
    repeat (2) begin @(posedge clk); #1; end
    chk("t2_flr", flr_rqst, 48'd1 << (1*NF + 6));
    lfl[1] = 6; door[1] = 1; drive_lifts();
    @(posedge clk); #1;
    chk("t2_clear_pending", up_pending, 0);
    @(posedge clk); #1;
    chk("t2_clear_flr", flr_rqst, 0);

    // tie goes to the lowest index
    do_reset();
    set_idle_lifts(3, 10, 3, 11);
    pulse_call(3, 0);
    wait_assign(12, got, n);
    chk("t3_got", got, 1);
    chk("t3_lift", assign_lift, 0);
    chk("t3_dir", assign_dir, 0);
    chk("t3_floor", assign_floor, 3);

    // direction penalties
    do_reset();
    set_idle_lifts(0, 4, 0, 8);
    svc[0] = 0; svc[2] = 0; mv[1] = 1; dr[1] = 0;
    drive_lifts();
    pulse_call(5, 1);
    wait_assign(12, got, n);
    chk("t4_got", got, 1);
    chk("t4_lift", assign_lift, 3);

    // owner leaves service -> re-dispatch
    do_reset();
    set_idle_lifts(0, 1, 7, 3);
    pulse_call(7, 1);
    wait_assign(12, got, n);
    chk("t5_first_lift", assign_lift, 2);
    repeat (2) begin @(posedge clk); #1; end
    svc[2] = 0; drive_lifts();
    exp_l = model_pick(7, 1);
    wait_assign(20, got, n);
    chk("t5_reassign_got", got, 1);
    chk("t5_reassign_lift", assign_lift, 3);
    chk("t5_reassign_model", assign_lift, exp_l);
    chk("t5_still_pending", up_pending[7], 1);
    repeat (3) begin @(posedge clk); #1; end

    // served while button held, no lifts in service
    hall_up[7] = 1'b1;
    lfl[3] = 7; door[3] = 1;
    for (int i = 0; i < NL; i++) svc[i] = 0;
    drive_lifts();
    @(posedge clk); #1;
    chk("t6_cleared", up_pending[7], 0);
    @(posedge clk); #1;
    chk("t6_relatched", up_pending[7], 1);
    hall_up = '0;
    wait_assign(20, got, n);
    chk("t6_no_assign", got, 0);
    chk("t6_pending_kept", up_pending[7], 1);

    // lowest-floor up calls first, then down calls
    do_reset();
    set_idle_lifts(0, 5, 9, 11);
    hall_up[9] = 1'b1; hall_up[4] = 1'b1;
    pulse_call(2, 0);
    wait_assign(12, got, n);
    chk("t7_a_floor", {assign_dir, assign_floor}, {1'b1, 4'd4});
    chk("t7_a_lift", assign_lift, 1);
    wait_assign(12, got, n);
    chk("t7_b_floor", {assign_dir, assign_floor}, {1'b1, 4'd9});
    chk("t7_b_lift", assign_lift, 2);
    wait_assign(12, got, n);
    chk("t7_c_floor", {assign_dir, assign_floor}, {1'b0, 4'd2});
    chk("t7_c_lift", assign_lift, 0);

    // randomized single calls against the cost model
    for (int it = 0; it < 40; it++) begin
      do_reset();
      for (int i = 0; i < NL; i++) begin
        lfl[i] = $urandom_range(0, NF - 1);
        mv[i]  = 1'($urandom_range(0, 1));
        dr[i]  = 1'($urandom_range(0, 1));
        svc[i] = ($urandom_range(0, 3) != 0);
        door[i] = 0;
      end
      drive_lifts();
      f  = $urandom_range(0, NF - 1);
      up = 1'($urandom_range(0, 1));
      car_rqst = 48'({$urandom(), $urandom()});
      exp_l = model_pick(f, up);
      pulse_call(f, up);
      wait_assign(12, got, n);
      if (exp_l < 0) begin
        chk("rnd_none", got, 0);
      end else begin
        chk("rnd_got", got, 1);
        chk("rnd_latency", n, 6);
        chk("rnd_lift", assign_lift, exp_l);
        chk("rnd_call", {assign_dir, assign_floor}, {up, 4'(f)});
        repeat (2) begin @(posedge clk); #1; end
        ev = car_rqst;
        ev[exp_l*NF + f] = 1'b1;
        chk("rnd_flr", flr_rqst, ev);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
